// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate unit, one bit position per clock, start/busy/done handshake.
// Optional abort input is enabled by defining SEQ_SHIFT_ABORT_EN.
module seq_shift_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  input  logic               sel1,
  input  logic               sel0,
  input  logic               cin,
`ifdef SEQ_SHIFT_ABORT_EN
  input  logic               abort,
`endif
  output logic [WIDTH-1:0]   f,
  output logic               cout,
  output logic               overflow,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_LOGICAL = 2'b00,
    M_ROTATE  = 2'b01,
    M_CARRY   = 2'b10,
    M_THROUGH = 2'b11
  } mode_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_f;
  logic               r_cout;
  logic               r_ovf;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_dir;
  mode_t              r_mode;

  logic [WIDTH-1:0]   w_step_f;
  logic               w_step_cout;
  logic               w_step_ovf;
  logic               w_abort;
  logic               w_last_step;
  mode_t              w_in_mode;

`ifdef SEQ_SHIFT_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_in_mode = mode_t'({sel1, sel0});

  // A zero shift amount still spends one SHIFT cycle (with no step) so every
  // operation occupies at least one busy cycle ahead of DONE.
  assign w_last_step = (r_cnt == SHAMT_W'(1)) || (r_cnt == '0);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of block ordering.
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the
    // signal unassigned, which would infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_abort)          w_next_state = S_IDLE;
        else if (w_last_step) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_SHIFT: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Single-bit step of the working register for the latched direction and mode
  always_comb begin
    w_step_f    = r_f;
    w_step_cout = r_cout;
    w_step_ovf  = r_ovf;
    if (!r_dir) begin
      unique case (r_mode)
        M_LOGICAL: w_step_f = {r_f[WIDTH-2:0], 1'b0};
        M_ROTATE:  w_step_f = {r_f[WIDTH-2:0], r_f[WIDTH-1]};
        M_CARRY: begin
          w_step_f    = {r_f[WIDTH-2:0], 1'b0};
          w_step_cout = r_f[WIDTH-1];
        end
        M_THROUGH: begin
          w_step_f    = {r_f[WIDTH-2:0], r_cout};
          w_step_cout = r_f[WIDTH-1];
          // sign change between the two top bits means a signed overflow
          w_step_ovf  = r_ovf | (r_f[WIDTH-1] ^ r_f[WIDTH-2]);
        end
        default: ;
      endcase
    end else begin
      unique case (r_mode)
        M_LOGICAL: w_step_f = {1'b0, r_f[WIDTH-1:1]};
        M_ROTATE:  w_step_f = {r_f[0], r_f[WIDTH-1:1]};
        M_CARRY: begin
          w_step_f    = {r_f[WIDTH-1], r_f[WIDTH-1:1]};
          w_step_cout = r_f[0];
        end
        M_THROUGH: begin
          w_step_f    = {r_cout, r_f[WIDTH-1:1]};
          w_step_cout = r_f[0];
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: load on accepted start, step during SHIFT, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_mode <= M_LOGICAL;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_f    <= x;
            r_cnt  <= shamt;
            r_dir  <= dir;
            r_mode <= w_in_mode;
            r_cout <= (w_in_mode == M_THROUGH) ? cin : 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (!w_abort && (r_cnt != '0)) begin
            r_f    <= w_step_f;
            r_cout <= w_step_cout;
            r_ovf  <= w_step_ovf;
            r_cnt  <= r_cnt - SHAMT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign f        = r_f;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: randomized and directed stimulus against a step-count reference model.
// Abort scenario is exercised when SEQ_SHIFT_ABORT_EN is defined.
module tb_seq_shift_unit;

  localparam int W  = 8;
  localparam int SW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  x;
  logic [SW-1:0] shamt;
  logic          dir;
  logic          sel1;
  logic          sel0;
  logic          cin;
  logic          abort;
  logic [W-1:0]  f;
  logic          cout;
  logic          overflow;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  seq_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x        (x),
    .shamt    (shamt),
    .dir      (dir),
    .sel1     (sel1),
    .sel0     (sel0),
    .cin      (cin),
`ifdef SEQ_SHIFT_ABORT_EN
    .abort    (abort),
`endif
    .f        (f),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] f;
    logic         c;
    logic         v;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result of n one-bit steps, computed with plain integer arithmetic.
  function automatic res_t ref_run(input logic [W-1:0] xi, input int n, input logic d,
                                   input logic [1:0] md, input logic ci);
    int   v;
    int   c;
    int   o;
    int   msb;
    int   lsb;
    res_t r;
    v = int'(xi);
    c = (md == 2'b11) ? int'(ci) : 0;
    o = 0;
    for (int i = 0; i < n; i++) begin
      msb = (v >> (W - 1)) & 1;
      lsb = v & 1;
      if (!d) begin
        case (md)
          2'b00: v = (v << 1) & 255;
          2'b01: v = ((v << 1) & 255) | msb;
          2'b10: begin v = (v << 1) & 255; c = msb; end
          default: begin
            o = o | (msb ^ ((v >> (W - 2)) & 1));
            v = ((v << 1) & 255) | c;
            c = msb;
          end
        endcase
      end else begin
        case (md)
          2'b00: v = v >> 1;
          2'b01: v = (v >> 1) | (lsb << (W - 1));
          2'b10: begin v = (v >> 1) | (msb << (W - 1)); c = lsb; end
          default: begin v = (v >> 1) | (c << (W - 1)); c = lsb; end
        endcase
      end
    end
    r.f = W'(v);
    r.c = c[0];
    r.v = o[0];
    return r;
  endfunction

  // Reference model: tracks the handshake in whole cycles and the expected result
  logic         m_busy;
  logic         m_done;
  logic         m_fv;
  int           m_left;
  int           m_steps;
  int           m_k;
  logic [W-1:0] m_x;
  logic         m_dir;
  logic [1:0]   m_md;
  logic         m_cin;
  res_t         m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_fv    <= 1'b1;
      m_left  <= 0;
      m_steps <= 0;
      m_res   <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (abort) begin
        m_busy <= 1'b0;
        m_fv   <= 1'b1;
        m_res  <= ref_run(m_x, m_steps, m_dir, m_md, m_cin);
      end else begin
        if (m_steps < m_k) m_steps <= m_steps + 1;
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_fv   <= 1'b1;
          m_res  <= ref_run(m_x, m_k, m_dir, m_md, m_cin);
        end
      end
    end else if (start) begin
      m_x     <= x;
      m_k     <= int'(shamt);
      m_dir   <= dir;
      m_md    <= {sel1, sel0};
      m_cin   <= cin;
      m_busy  <= 1'b1;
      m_fv    <= 1'b0;
      m_steps <= 0;
      m_left  <= (shamt == '0) ? 1 : int'(shamt);
    end
  end

  // Compare process: handshake every cycle, result whenever it is meaningful
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    if (m_fv) begin
      check("f", 32'(f), 32'(m_res.f));
      check("cout", 32'(cout), 32'(m_res.c));
      check("overflow", 32'(overflow), 32'(m_res.v));
    end
  end

  // Issue one operation (caller sits on a falling edge); bcnt counts busy cycles.
  task automatic do_op(input logic [W-1:0] xi, input int k, input logic d, input logic [1:0] md,
                       input logic ci, input bit spam, output int bcnt);
    bit ended;
    x     = xi;
    shamt = SW'(k);
    dir   = d;
    {sel1, sel0} = md;
    cin   = ci;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcnt  = 0;
    ended = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      bcnt++;
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      x     = W'($urandom);
      shamt = SW'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    if (!ended) check("op_timeout", 32'(busy), 32'd0);
  endtask

  int bc;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x     = '0;
    shamt = '0;
    dir   = 1'b0;
    sel1  = 1'b0;
    sel0  = 1'b0;
    cin   = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_f", 32'(f), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pin the model against hand-computed values
    check("pin_ref_lsl1", 32'(ref_run(8'hB5, 1, 1'b0, 2'b00, 1'b0)), 32'({8'h6A, 1'b0, 1'b0}));
    check("pin_ref_rol3", 32'(ref_run(8'hB5, 3, 1'b0, 2'b01, 1'b0)), 32'({8'hAD, 1'b0, 1'b0}));
    check("pin_ref_rcl1", 32'(ref_run(8'hB5, 1, 1'b0, 2'b11, 1'b1)), 32'({8'h6B, 1'b1, 1'b1}));
    check("pin_ref_asr2", 32'(ref_run(8'hB5, 2, 1'b1, 2'b10, 1'b0)), 32'({8'hED, 1'b0, 1'b0}));

    // Directed cases from the worked examples
    do_op(8'hB5, 1, 1'b0, 2'b00, 1'b0, 1'b0, bc);
    check("lsl1_busy_cycles", 32'(bc), 32'd2);
    check("lsl1_f", 32'({f, cout, overflow}), 32'({8'h6A, 1'b0, 1'b0}));

    do_op(8'hB5, 3, 1'b0, 2'b01, 1'b0, 1'b0, bc);
    check("rol3_busy_cycles", 32'(bc), 32'd4);
    check("rol3_f", 32'({f, cout}), 32'({8'hAD, 1'b0}));

    do_op(8'hB5, 1, 1'b0, 2'b11, 1'b1, 1'b0, bc);
    check("rcl1_f", 32'({f, cout, overflow}), 32'({8'h6B, 1'b1, 1'b1}));

    do_op(8'hB5, 2, 1'b1, 2'b10, 1'b0, 1'b1, bc);
    check("asr2_f_start_spam", 32'({f, cout}), 32'({8'hED, 1'b0}));

    do_op(8'h5A, 0, 1'b0, 2'b01, 1'b0, 1'b0, bc);
    check("shamt0_busy_cycles", 32'(bc), 32'd2);
    check("shamt0_f", 32'(f), 32'h5A);

    // Idle hold: result stays put while no start arrives
    repeat (3) @(negedge clk);
    check("idle_hold_f", 32'(f), 32'h5A);

    // Randomized operations, including shift amounts beyond the width
    for (int n = 0; n < 60; n++) begin
      int k;
      k = int'($urandom_range(0, 15));
      do_op(W'($urandom), k, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), bc);
      check("rand_busy_cycles", 32'(bc), 32'((k == 0 ? 1 : k) + 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a long operation
    x = 8'hB5; shamt = SW'(9); dir = 1'b0; {sel1, sel0} = 2'b11; cin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_f", 32'(f), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

`ifdef SEQ_SHIFT_ABORT_EN
    // Abort after two rotate steps: back to idle with the partial value, no done
    x = 8'hB5; shamt = SW'(9); dir = 1'b0; {sel1, sel0} = 2'b01; cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_f", 32'(f), 32'hD6);
    repeat (2) @(negedge clk);
    check("abort_hold_f", 32'(f), 32'hD6);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
